// File: rtl/adder_sched_pkg.sv
// Shared types and constants for the nibble-serial add scheduler.
package adder_sched_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_t;
endpackage

// File: rtl/adder_sched_nibble_adder.sv
// 4-bit ripple-carry adder cell shared by both requesters; purely combinational.
module nibble_adder
  import adder_sched_pkg::*;
(
  input  logic [NIBBLE_W-1:0] in0,
  input  logic [NIBBLE_W-1:0] in1,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] out,
  output logic                cout
);
  logic [NIBBLE_W:0] c;

  assign c[0] = cin;
  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign out[i]  = in0[i] ^ in1[i] ^ c[i];
    assign c[i+1]  = (in0[i] & in1[i]) | (c[i] & (in0[i] ^ in1[i]));
  end
  assign cout = c[NIBBLE_W];
endmodule

// File: rtl/adder_sched.sv
// Two-requester scheduler sharing one nibble adder; LS nibble first, carry registered.
// ADDER_SCHED_RR_EN selects round-robin arbitration, otherwise fixed priority A over B.
module adder_sched
  import adder_sched_pkg::*;
#(
  parameter int NIBBLES = 4,
  localparam int W  = NIBBLE_W * NIBBLES,
  localparam int NW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_a,
  input  logic [W-1:0] op1_a,
  input  logic [W-1:0] op2_a,
  output logic         gnt_a,
  output logic         done_a,
  input  logic         req_b,
  input  logic [W-1:0] op1_b,
  input  logic [W-1:0] op2_b,
  output logic         gnt_b,
  output logic         done_b,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);
  state_t         state_q, state_d;
  owner_t         owner_q, owner_d;
  logic [NW-1:0]  nib_q, nib_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   op1_q, op1_d, op2_q, op2_d;
  logic [W-1:0]   res_q, res_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic           win_a, win_b;
  logic [NIBBLE_W-1:0] add_out;
  logic           add_cout;

`ifdef ADDER_SCHED_RR_EN
  // rr_q names the requester that wins the next tie
  owner_t rr_q, rr_d;
  always_comb begin
    win_a = req_a & (~req_b | (rr_q == OWN_A));
    win_b = req_b & (~req_a | (rr_q == OWN_B));
  end
`else
  always_comb begin
    win_a = req_a;
    win_b = req_b & ~req_a;
  end
`endif

  assign gnt_a  = ~rst & (state_q == IDLE) & win_a;
  assign gnt_b  = ~rst & (state_q == IDLE) & win_b;
  assign done_a = (state_q == DONE) & (owner_q == OWN_A);
  assign done_b = (state_q == DONE) & (owner_q == OWN_B);
  assign busy   = (state_q != IDLE);
  assign sum    = sum_q;
  assign cout   = cout_q;

  nibble_adder u_add (
    .in0  (op1_q[NIBBLE_W-1:0]),
    .in1  (op2_q[NIBBLE_W-1:0]),
    .cin  (carry_q),
    .out  (add_out),
    .cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    nib_d   = nib_q;
    carry_d = carry_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef ADDER_SCHED_RR_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_a || gnt_b) begin
          op1_d   = gnt_a ? op1_a : op1_b;
          op2_d   = gnt_a ? op2_a : op2_b;
          owner_d = gnt_a ? OWN_A : OWN_B;
          carry_d = 1'b0;
          nib_d   = '0;
          state_d = RUN;
`ifdef ADDER_SCHED_RR_EN
          rr_d    = gnt_a ? OWN_B : OWN_A;
`endif
        end
      end
      RUN: begin
        // operands shift down so the adder always sees the current nibble at bit 0
        res_d[nib_q*NIBBLE_W +: NIBBLE_W] = add_out;
        carry_d = add_cout;
        op1_d   = op1_q >> NIBBLE_W;
        op2_d   = op2_q >> NIBBLE_W;
        if (nib_q == NW'(NIBBLES-1)) begin
          sum_d   = res_d;
          cout_d  = add_cout;
          state_d = DONE;
        end else begin
          nib_d   = nib_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_A;
      nib_q   <= '0;
      carry_q <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef ADDER_SCHED_RR_EN
      rr_q    <= OWN_A;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      nib_q   <= nib_d;
      carry_q <= carry_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef ADDER_SCHED_RR_EN
      rr_q    <= rr_d;
`endif
    end
  end
endmodule

// File: tb/tb_adder_sched.sv
// Directed bench for adder_sched at NIBBLES=4; inputs change and outputs are sampled on negedge.
module tb_adder_sched;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_a, req_b;
  logic [W-1:0] op1_a, op2_a, op1_b, op2_b;
  logic         gnt_a, gnt_b, done_a, done_b, cout, busy;
  logic [W-1:0] sum;

  int n_cmp = 0;
  int n_err = 0;

  adder_sched #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .op1_a(op1_a), .op2_a(op2_a), .gnt_a(gnt_a), .done_a(done_a),
    .req_b(req_b), .op1_b(op1_b), .op2_b(op2_b), .gnt_b(gnt_b), .done_b(done_b),
    .sum(sum), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1;
    op1_a = 16'h0001; op2_a = 16'h0001; op1_b = 16'h0002; op2_b = 16'h0002;
    @(negedge clk); #1;
    n_cmp++;
    if ({gnt_a, gnt_b, done_a, done_b, busy, cout} !== 6'b0 || sum !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_outputs: gnt=%b%b done=%b%b busy=%b cout=%b sum=%h, required all 0",
               gnt_a, gnt_b, done_a, done_b, busy, cout, sum);
    end
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_add_a();
    @(negedge clk);
    req_a = 1'b1; op1_a = 16'h1234; op2_a = 16'h4321; #1;
    n_cmp++;
    if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
      n_err++; $display("FAIL add_a_gnt: gnt_a=%b gnt_b=%b, required 1 0", gnt_a, gnt_b);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); req_a = 1'b0; #1;
      n_cmp++;
      if (done_a !== (k == 5) || done_b !== 1'b0 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL add_a_seq T+%0d: done_a=%b done_b=%b busy=%b, required %b 0 1",
                 k, done_a, done_b, busy, k == 5);
      end
    end
    n_cmp++;
    if (sum !== 16'h5555 || cout !== 1'b0) begin
      n_err++; $display("FAIL add_a_sum: sum=%h cout=%b, required 5555 0", sum, cout);
    end
  endtask

  task automatic test_add_b_carry();
    @(negedge clk);
    req_b = 1'b1; op1_b = 16'hFFFF; op2_b = 16'h0001; #1;
    n_cmp++;
    if (gnt_b !== 1'b1 || gnt_a !== 1'b0) begin
      n_err++; $display("FAIL add_b_gnt: gnt_b=%b gnt_a=%b, required 1 0", gnt_b, gnt_a);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); req_b = 1'b0; #1;
      n_cmp++;
      if (done_b !== (k == 5) || done_a !== 1'b0) begin
        n_err++;
        $display("FAIL add_b_seq T+%0d: done_b=%b done_a=%b, required %b 0", k, done_b, done_a, k == 5);
      end
      if (k < 5) begin
        n_cmp++;
        if (sum !== 16'h5555) begin
          n_err++; $display("FAIL add_b_hold T+%0d: sum=%h, required 5555", k, sum);
        end
      end
    end
    n_cmp++;
    if (sum !== 16'h0000 || cout !== 1'b1) begin
      n_err++; $display("FAIL add_b_sum: sum=%h cout=%b, required 0000 1", sum, cout);
    end
  endtask

  task automatic test_arbitration();
    logic exp_b2;
    logic [W-1:0] exp_sum2;
`ifdef ADDER_SCHED_RR_EN
    exp_b2 = 1'b1; exp_sum2 = 16'h0030;
`else
    exp_b2 = 1'b0; exp_sum2 = 16'h0003;
`endif
    @(negedge clk);
    req_a = 1'b1; op1_a = 16'h0001; op2_a = 16'h0002;
    req_b = 1'b1; op1_b = 16'h0010; op2_b = 16'h0020; #1;
    n_cmp++;
    if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
      n_err++; $display("FAIL arb_first: gnt_a=%b gnt_b=%b, required 1 0", gnt_a, gnt_b);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (gnt_a !== 1'b0 || gnt_b !== 1'b0 || done_a !== (k == 5)) begin
        n_err++;
        $display("FAIL arb_run T+%0d: gnt=%b%b done_a=%b, required 00 %b", k, gnt_a, gnt_b, done_a, k == 5);
      end
    end
    n_cmp++;
    if (sum !== 16'h0003) begin
      n_err++; $display("FAIL arb_sum1: sum=%h, required 0003", sum);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (gnt_b !== exp_b2 || gnt_a !== ~exp_b2) begin
      n_err++; $display("FAIL arb_second T+6: gnt_a=%b gnt_b=%b, required %b %b", gnt_a, gnt_b, ~exp_b2, exp_b2);
    end
    for (int k = 7; k <= 11; k++) begin
      @(negedge clk); req_a = 1'b0; req_b = 1'b0; #1;
    end
    n_cmp++;
    if (done_b !== exp_b2 || done_a !== ~exp_b2 || sum !== exp_sum2) begin
      n_err++;
      $display("FAIL arb_done2 T+11: done_a=%b done_b=%b sum=%h, required %b %b %h",
               done_a, done_b, sum, ~exp_b2, exp_b2, exp_sum2);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    req_a = 1'b1; op1_a = 16'h1111; op2_a = 16'h2222; #1;
    n_cmp++;
    if (gnt_a !== 1'b1) begin
      n_err++; $display("FAIL midrst_gnt: gnt_a=%b, required 1", gnt_a);
    end
    @(negedge clk); req_a = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    n_cmp++;
    if (busy !== 1'b0 || done_a !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_clear: busy=%b done_a=%b sum=%h cout=%b, required 0 0 0000 0", busy, done_a, sum, cout);
    end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (done_a !== 1'b0 || busy !== 1'b0 || sum !== 16'h0000) begin
        n_err++;
        $display("FAIL midrst_quiet %0d: done_a=%b busy=%b sum=%h, required 0 0 0000", k, done_a, busy, sum);
      end
    end
    req_a = 1'b1; op1_a = 16'h00FF; op2_a = 16'h0001; #1;
    n_cmp++;
    if (gnt_a !== 1'b1) begin
      n_err++; $display("FAIL midrst_regnt: gnt_a=%b, required 1", gnt_a);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); req_a = 1'b0; #1;
    end
    n_cmp++;
    if (done_a !== 1'b1 || sum !== 16'h0100 || cout !== 1'b0) begin
      n_err++; $display("FAIL midrst_sum: done_a=%b sum=%h cout=%b, required 1 0100 0", done_a, sum, cout);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_a = 1'b1; op1_a = 16'h8000; op2_a = 16'h8000; #1;
    n_cmp++;
    if (gnt_a !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL b2b_gnt: gnt_a=%b busy=%b, required 1 0", gnt_a, busy);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (gnt_a !== 1'b0 || busy !== 1'b1 || done_a !== (k == 5)) begin
        n_err++;
        $display("FAIL b2b_run T+%0d: gnt_a=%b busy=%b done_a=%b, required 0 1 %b", k, gnt_a, busy, done_a, k == 5);
      end
      if (k < 5) begin
        n_cmp++;
        if (sum !== 16'h0100) begin
          n_err++; $display("FAIL b2b_hold T+%0d: sum=%h, required 0100", k, sum);
        end
      end
    end
    n_cmp++;
    if (sum !== 16'h0000 || cout !== 1'b1) begin
      n_err++; $display("FAIL b2b_sum1: sum=%h cout=%b, required 0000 1", sum, cout);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (gnt_a !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL b2b_regnt T+6: gnt_a=%b busy=%b, required 1 0", gnt_a, busy);
    end
    @(negedge clk);
    req_a = 1'b0; op1_a = 16'h0001; op2_a = 16'h0001;
    for (int k = 8; k <= 11; k++) begin
      @(negedge clk); #1;
    end
    n_cmp++;
    if (done_a !== 1'b1 || sum !== 16'h0000 || cout !== 1'b1) begin
      n_err++; $display("FAIL b2b_sum2 T+11: done_a=%b sum=%h cout=%b, required 1 0000 1", done_a, sum, cout);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || done_a !== 1'b0) begin
      n_err++; $display("FAIL b2b_idle: busy=%b done_a=%b, required 0 0", busy, done_a);
    end
  endtask

  initial begin
    test_reset();
    test_add_a();
    test_add_b_carry();
    test_arbitration();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
